// File: rtl/mire_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mire_pkg
// Brief    : Shared types and constants for the wshb_mire test-pattern master.
// Revision : 1.0 - initial release
// ============================================================================
package mire_pkg;

   typedef logic [31:0] pixel_t;

   localparam pixel_t MIRE_WHITE = 32'h00FF_FFFF;
   localparam pixel_t MIRE_BLACK = 32'h0000_0000;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_WRITE = 2'd1,
      ST_YIELD = 2'd2
   } mire_state_t;

   function automatic pixel_t mire_pixel(input logic on_line);
      return on_line ? MIRE_WHITE : MIRE_BLACK;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wshb_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wshb_if
// Brief    : Wishbone B4 bus bundle (32-bit data, byte address) with modports.
// Revision : 1.0 - initial release
// ============================================================================
interface wshb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic [3:0]  sel;
   logic        ack;
   logic        err;
   logic        rty;
   logic [2:0]  cti;
   logic [1:0]  bte;

   modport master (
      output cyc, stb, we, adr, dat_ms, sel, cti, bte,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output dat_sm, ack, err, rty
   );
endinterface
`default_nettype wire

// File: rtl/mire_xy_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mire_xy_counter
// Brief    : Raster x/y position counters advancing on accepted beats.
// Revision : 1.0 - initial release
// ============================================================================
module mire_xy_counter #(
   parameter int HDISP = 800,
   parameter int VDISP = 480,
   parameter int XW    = $clog2(HDISP + 1),
   parameter int YW    = $clog2(VDISP + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_accept,
   output logic [XW-1:0] o_x_nxt,
   output logic [YW-1:0] o_y_nxt,
   output logic          o_frame_end
);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          w_x_last;
   logic          w_y_last;

   assign w_x_last    = (r_x == XW'(HDISP - 1));
   assign w_y_last    = (r_y == YW'(VDISP - 1));
   assign o_frame_end = i_accept & w_x_last & w_y_last;

   // Next position is exported so the master can register address/data for it.
   always_comb begin
      o_x_nxt = r_x;
      o_y_nxt = r_y;
      if (i_accept) begin
         if (w_x_last) begin
            o_x_nxt = '0;
            o_y_nxt = w_y_last ? '0 : r_y + YW'(1);
         end else begin
            o_x_nxt = r_x + XW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else begin
         r_x <= o_x_nxt;
         r_y <= o_y_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wshb_mire.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wshb_mire
// Brief    : Wishbone master drawing a grid test pattern into the framebuffer,
//            yielding the bus after every burst. WSHB_MIRE_BURST_EN enables
//            incrementing-burst cycle tags on cti.
// Revision : 1.0 - initial release
// ============================================================================
module wshb_mire
   import mire_pkg::*;
#(
   parameter int HDISP        = 800,
   parameter int VDISP        = 480,
   parameter int BURST_LEN    = 16,
   parameter int YIELD_CYCLES = 1,
   parameter int GRID         = 16
) (
   input  logic    clk,
   input  logic    rst_n,
   wshb_if.master  wshb_ifm,
   output logic    frame_done
);

   localparam int XW = $clog2(HDISP + 1);
   localparam int YW = $clog2(VDISP + 1);
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int WW = $clog2(YIELD_CYCLES + 1);

   mire_state_t   r_state;
   mire_state_t   w_state_nxt;
   logic [BW-1:0] r_beat;
   logic [WW-1:0] r_wait;
   logic [31:0]   r_adr;
   pixel_t        r_dat;
   logic [2:0]    r_cti;
   logic          r_frame_done;

   logic          w_accept;
   logic          w_burst_end;
   logic          w_yield_end;
   logic [XW-1:0] w_x_nxt;
   logic [YW-1:0] w_y_nxt;
   logic          w_frame_end;
   logic [31:0]   w_adr_nxt;
   logic          w_on_line;

   // cyc/stb decode straight from state so an async reset drops them at once.
   assign w_accept    = (r_state == ST_WRITE) & wshb_ifm.ack;
   assign w_burst_end = w_accept & (r_beat == BW'(BURST_LEN - 1));
   assign w_yield_end = (r_state == ST_YIELD) & (r_wait == WW'(YIELD_CYCLES - 1));

   mire_xy_counter #(
      .HDISP (HDISP),
      .VDISP (VDISP),
      .XW    (XW),
      .YW    (YW)
   ) u_xy (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_accept    (w_accept),
      .o_x_nxt     (w_x_nxt),
      .o_y_nxt     (w_y_nxt),
      .o_frame_end (w_frame_end)
   );

   assign w_adr_nxt = (32'(w_y_nxt) * 32'(HDISP) + 32'(w_x_nxt)) << 2;
   assign w_on_line = ((32'(w_x_nxt) % 32'(GRID)) == 32'd0) ||
                      ((32'(w_y_nxt) % 32'(GRID)) == 32'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_INIT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT:  w_state_nxt = ST_WRITE;
         ST_WRITE: if (w_burst_end) w_state_nxt = ST_YIELD;
         ST_YIELD: if (w_yield_end) w_state_nxt = ST_WRITE;
         default:  w_state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat <= '0;
         r_wait <= '0;
      end else begin
         if (w_burst_end)   r_beat <= '0;
         else if (w_accept) r_beat <= r_beat + BW'(1);

         if (r_state == ST_YIELD) r_wait <= w_yield_end ? '0 : r_wait + WW'(1);
         else                     r_wait <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_adr        <= '0;
         r_dat        <= MIRE_WHITE;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame_end;
         if (w_accept) begin
            r_adr <= w_adr_nxt;
            r_dat <= mire_pixel(w_on_line);
         end
      end
   end

`ifdef WSHB_MIRE_BURST_EN
   logic [BW-1:0] w_beat_nxt;
   logic          w_enter_write;

   assign w_beat_nxt    = w_burst_end ? '0 : (w_accept ? r_beat + BW'(1) : r_beat);
   assign w_enter_write = (r_state != ST_WRITE) & (w_state_nxt == ST_WRITE);

   // Tag describes the beat about to be presented, hence the look-ahead count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cti <= CTI_CLASSIC;
      end else if (w_accept | w_enter_write) begin
         r_cti <= (w_beat_nxt == BW'(BURST_LEN - 1)) ? CTI_EOB : CTI_INCR;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cti <= CTI_CLASSIC;
      else        r_cti <= CTI_CLASSIC;
   end
`endif

   assign wshb_ifm.cyc    = (r_state == ST_WRITE);
   assign wshb_ifm.stb    = (r_state == ST_WRITE);
   assign wshb_ifm.we     = 1'b1;
   assign wshb_ifm.sel    = 4'hF;
   assign wshb_ifm.bte    = 2'b00;
   assign wshb_ifm.adr    = r_adr;
   assign wshb_ifm.dat_ms = r_dat;
   assign wshb_ifm.cti    = r_cti;
   assign frame_done      = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_wshb_mire.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wshb_mire
// Brief    : Directed self-checking bench for wshb_mire (8x4 frame, grid 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wshb_mire;
   import mire_pkg::*;

   localparam int HD = 8;
   localparam int VD = 4;
   localparam int BL = 4;
   localparam int YC = 1;
   localparam int GR = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_done;

   wshb_if wb ();

   wshb_mire #(
      .HDISP        (HD),
      .VDISP        (VD),
      .BURST_LEN    (BL),
      .YIELD_CYCLES (YC),
      .GRID         (GR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wshb_ifm   (wb),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: 0 = INIT, 1 = WRITE, 2 = YIELD
   int          m_st;
   int          m_idx;
   int          m_beat;
   logic        m_fd;
   int          fd_count;
   logic [31:0] fd_adr;
   logic [31:0] cap [32];
   logic [31:0] acc_log [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pix(input int idx);
      int x;
      int y;
      x = idx % HD;
      y = idx / HD;
      return ((x % GR) == 0 || (y % GR) == 0) ? 32'h00FF_FFFF : 32'h0000_0000;
   endfunction

   function automatic logic [31:0] cti_exp(input int beat);
`ifdef WSHB_MIRE_BURST_EN
      return (beat == BL - 1) ? 32'h7 : 32'h2;
`else
      return (beat < 0) ? 32'h1 : 32'h0;
`endif
   endfunction

   // Checks the current cycle at the falling edge, drives ack/err, runs one clock.
   task automatic step(input logic a, input logic e);
      logic exp_cyc;
      exp_cyc = (m_st == 1);
      chk("cyc", 32'(wb.cyc), 32'(exp_cyc));
      chk("stb", 32'(wb.stb), 32'(exp_cyc));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      if (frame_done) begin
         fd_count++;
         fd_adr = wb.adr;
      end
      if (m_st == 1) begin
         chk("adr", wb.adr, 32'(m_idx * 4));
         chk("dat", wb.dat_ms, pix(m_idx));
         chk("cti", 32'(wb.cti), cti_exp(m_beat));
         if (a) begin
            cap[m_idx] = wb.dat_ms;
            acc_log.push_back(wb.adr);
         end
      end
      wb.ack = a;
      wb.err = e;
      @(posedge clk);
      m_fd = 1'b0;
      case (m_st)
         0: m_st = 1;
         1: if (a) begin
               if (m_idx == HD * VD - 1) begin
                  m_idx = 0;
                  m_fd  = 1'b1;
               end else begin
                  m_idx++;
               end
               m_beat++;
               if (m_beat == BL) begin
                  m_beat = 0;
                  m_st   = 2;
               end
            end
         default: m_st = 1;
      endcase
      @(negedge clk);
   endtask

   initial begin
      wb.ack    = 1'b0;
      wb.err    = 1'b0;
      wb.rty    = 1'b0;
      wb.dat_sm = 32'h0;
      m_st = 0; m_idx = 0; m_beat = 0; m_fd = 1'b0;
      fd_count = 0; fd_adr = 32'hDEAD_BEEF;

      repeat (3) @(negedge clk);
      chk("rst_cyc", 32'(wb.cyc), 32'h0);
      chk("rst_stb", 32'(wb.stb), 32'h0);
      chk("rst_adr", wb.adr, 32'h0);
      chk("rst_dat", wb.dat_ms, 32'h00FF_FFFF);
      chk("rst_cti", 32'(wb.cti), 32'h0);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
      chk("rst_we", 32'(wb.we), 32'h1);
      chk("rst_sel", 32'(wb.sel), 32'hF);
      chk("rst_bte", 32'(wb.bte), 32'h0);

      // Release: one INIT cycle, then continuous ack over a whole frame
      rst_n = 1'b1;
      #1;
      step(1'b0, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, 1'b0);

      chk("seq_0", acc_log[0], 32'd0);
      chk("seq_1", acc_log[1], 32'd4);
      chk("seq_2", acc_log[2], 32'd8);
      chk("seq_3", acc_log[3], 32'd12);
      chk("seq_4", acc_log[4], 32'd16);
      chk("accept_count", 32'(acc_log.size()), 32'd32);
      chk("fd_count", 32'(fd_count), 32'd1);
      chk("fd_adr", fd_adr, 32'd0);
      chk("pix_1_1", cap[9], 32'h0000_0000);
      chk("pix_4_1", cap[12], 32'h00FF_FFFF);
      chk("pix_0_2", cap[16], 32'h00FF_FFFF);
      chk("pix_7_0", cap[7], 32'h00FF_FFFF);
      chk("pix_5_3", cap[29], 32'h0000_0000);
      chk("pix_3_2", cap[19], 32'h0000_0000);

      // Wait states on adr 8
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0);
      chk("wait_adr", wb.adr, 32'd8);
      chk("wait_stb", 32'(wb.stb), 32'h1);
      step(1'b1, 1'b0);
      chk("after_wait_adr", wb.adr, 32'd12);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);   // yield cycle: ack must be ignored

      // Error retry on adr 20
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      chk("retry_adr", wb.adr, 32'd20);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("retry_tenure_end", 32'(wb.cyc), 32'h0);
      step(1'b0, 1'b0);

      // Mid-frame reset at adr 56
      for (int i = 0; i < 20 && !(m_st == 1 && m_idx == 14); i++) step(1'b1, 1'b0);
      chk("reach_56", wb.adr, 32'd56);
      rst_n  = 1'b0;
      wb.ack = 1'b0;
      wb.err = 1'b0;
      #1;
      chk("mid_rst_cyc", 32'(wb.cyc), 32'h0);
      chk("mid_rst_stb", 32'(wb.stb), 32'h0);
      chk("mid_rst_adr", wb.adr, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_st = 0; m_idx = 0; m_beat = 0; m_fd = 1'b0;
      #1;
      step(1'b0, 1'b0);
      chk("restart_cyc", 32'(wb.cyc), 32'h1);
      chk("restart_adr", wb.adr, 32'h0);
      chk("restart_dat", wb.dat_ms, 32'h00FF_FFFF);
      repeat (6) step(1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wshb_mire.md
# wshb_mire

Test-pattern ("mire") Wishbone master. It continuously writes a grid pattern into the framebuffer in SDRAM and periodically releases the bus so the Wishbone interconnect can hand the token to the VGA reader. It sits directly upstream of the Wishbone interconnect, on that block's mire slave port.

## Interface
- `HDISP`, default 800: pixels per line.
- `VDISP`, default 480: lines per frame.
- `BURST_LEN`, default 16: accepted writes per bus tenure before yielding; must be ≥1.
- `YIELD_CYCLES`, default 1: cycles with `cyc`=0 between tenures; must be ≥1.
- `GRID`, default 16: grid period in pixels; must be a power of two.
- `clk` in 1: sole clock; also drives the Wishbone bus.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wshb_ifm` (`wshb_if.master`) in/out: Wishbone master towards the interconnect.
- `frame_done` out 1: one-cycle pulse when the last pixel of a frame is acknowledged.

## Operation
- States:
  - `INIT`: one cycle after reset release, then `WRITE`.
  - `WRITE`: `cyc`=`stb`=1.
  - `YIELD`: `cyc`=`stb`=0, lasts `YIELD_CYCLES` cycles, then `WRITE`.
- Beat acceptance: a beat is accepted when `cyc & stb & ack`. Only accepted beats advance counters.
- `err` or `rty` during `WRITE`: same address and data re-presented next cycle; counters do not advance.
- Position counters: `x` in 0..HDISP-1, `y` in 0..VDISP-1.
  - On accept, `x` increments.
  - At `x`=HDISP-1, `x` wraps to 0 and `y` increments.
  - At `y`=VDISP-1 with `x`=HDISP-1, both wrap to 0 and `frame_done` pulses.
- Burst counter: counts accepted beats. On the BURST_LEN-th accept, the counter clears and the FSM goes to `YIELD`.
  - Frame wrap does not force a yield; bursts cross frame boundaries.
- Address: `adr` = 4·(y·HDISP + x), byte addressing, 32-bit words. The product is computed to full `adr` width, without truncation.
- Data: `dat_ms` = 32'h00FFFFFF when x mod GRID = 0 or y mod GRID = 0, else 32'h00000000.
- Fixed outputs: `we`=1, `sel`=4'hF, `bte`=2'b00.
- Ignored inputs: `dat_sm` is never used. `ack` outside `WRITE` is ignored.
- Reset values: `cyc`=0, `stb`=0, `adr`=0, `dat_ms`=32'h00FFFFFF (pixel 0,0), `cti`=3'b000, `frame_done`=0; all counters 0; state `INIT`.
- Reset mid-transfer: `cyc`/`stb` drop immediately (asynchronous). Drawing restarts at pixel (0,0); the partially written frame is simply overwritten.

## Timing
- `adr`, `dat_ms` and `cti` are registered and change only in the cycle after an accept, or on entry to `WRITE`.
- `stb` stays high with stable `adr`/`dat_ms` until `ack`. A stall of any length, including the interconnect token being held by the VGA reader, is legal.
- Throughput: one beat per cycle while `ack` is held high.
- Per tenure: exactly BURST_LEN accepted beats, then exactly YIELD_CYCLES cycles with `cyc`=0. This guarantees the interconnect sees `cyc` fall.
- `frame_done` is high in the cycle after the accept of pixel (HDISP-1, VDISP-1).

## Configuration
- Macro `WSHB_MIRE_BURST_EN`.
- Defined: registered-feedback incrementing burst.
  - `cti`=3'b010 on every beat of a tenure except the last.
  - `cti`=3'b111 on the BURST_LEN-th beat.
  - If BURST_LEN=1, the only beat carries `cti`=3'b111.
- Undefined: `cti`=3'b000 (classic cycle) always.
- All other behaviour is identical in both cases.

## Structure
- Package `mire_pkg`:
  - Pixel type (32-bit).
  - `MIRE_WHITE`/`MIRE_BLACK` constants.
  - `CTI_CLASSIC`/`CTI_INCR`/`CTI_EOB` constants.
  - FSM state enum.
- Sub-module `mire_xy_counter`: x/y counters with wrap, accept input, and frame-end flag.
- Address/data formation and the FSM stay in `wshb_mire`.

## Test plan
Benches use HDISP=8, VDISP=4, BURST_LEN=4, YIELD_CYCLES=1, GRID=4.
- **Continuous ack:** slave acks every cycle.
  - `adr` sequence is 0,4,8,12, then `cyc`=0 for 1 cycle, then 16,20,…
  - After 32 accepts, `frame_done` pulses and `adr` returns to 0.
- **Pattern check:** capture one frame of writes.
  - `dat_ms` = 32'h00FFFFFF at x ∈ {0,4} or y=0; 32'h00000000 elsewhere (e.g. (1,1) at `adr`=36).
- **Wait states:** `ack` withheld 5 cycles on the beat at `adr`=8.
  - `stb` stays high with `adr`=8 and data stable for all 5 cycles; the sequence then continues at 12.
- **Error retry:** `err` on the beat at `adr`=20.
  - Next beat presents `adr`=20 again; the tenure still contains 4 accepted beats.
- **Burst tags:** with `WSHB_MIRE_BURST_EN` defined, `cti` = 010,010,010,111 per tenure. Undefined, `cti`=000 throughout.
- **Mid-frame reset:** assert `rst_n`=0 at `adr`=56.
  - `cyc`/`stb` fall in the same cycle.
  - After release, one `INIT` cycle, then the first write is `adr`=0 with data 32'h00FFFFFF.
